// File: rtl/sd_router_pkg.sv
// Shared types and limits for the SPI SD router: channel mapping states,
// LED mode selectors and a chip-select conflict helper.
package sd_router_pkg;

    typedef enum logic [1:0] {
        BASE   = 2'd0,
        VIRT   = 2'd1,
        PEND_V = 2'd2,
        PEND_B = 2'd3
    } ch_state_t;

    localparam int LED_PHYS = 0;
    localparam int LED_ANY  = 1;
    localparam int MAX_CS   = 4;

    // True when more than one active-low select is asserted.
    function automatic logic multi_low(input logic [MAX_CS-1:0] cs_n);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < MAX_CS; i++) begin
            if (!cs_n[i]) n++;
        end
        return n > 1;
    endfunction

endpackage

// File: rtl/sd_act_timer.sv
// Per-channel activity timer: kick reloads to zero, counts up saturating at
// TIMEOUT; act is the registered "recently active" flag.
module sd_act_timer #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic kick,
    output logic act
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] timer;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            timer <= TMAX;
            act   <= 1'b0;
        end else begin
            act <= (timer < TMAX);
            if (kick) begin
                timer <= '0;
            end else if (timer < TMAX) begin
                timer <= timer + TW'(1);
            end
        end
    end

endmodule

// File: rtl/sd_spi_router.sv
// Routes the core SPI SD bus to the physical slot or per-CS virtual sd_card
// instances; remaps only while a channel is deselected, tracks activity.
module sd_spi_router
    import sd_router_pkg::*;
#(
    parameter int NUM_CS   = 2,
    parameter int TIMEOUT  = 1000000,
    parameter int LED_MODE = 0,
    parameter int SETTLE   = 2
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [NUM_CS-1:0] img_mounted,
    input  logic [NUM_CS-1:0] img_nz,
    input  logic [NUM_CS-1:0] cs_n_i,
    input  logic              sclk_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic [NUM_CS-1:0] vsd_cs_n_o,
    output logic              vsd_sclk_o,
    output logic              vsd_mosi_o,
    input  logic [NUM_CS-1:0] vsd_miso_i,
    output logic              SD_CS,
    output logic              SD_SCK,
    output logic              SD_MOSI,
    input  logic              SD_MISO,
    output logic [NUM_CS-1:0] vsd_sel_o,
    output logic [NUM_CS-1:0] act_o,
    output logic              led_o,
    output logic              cs_conflict_o
);

    localparam int SW = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SMAX = SW'(SETTLE);

    logic [NUM_CS-1:0] win;
    logic              win_valid;
    logic [NUM_CS-1:0] cand;
    logic [NUM_CS-1:0] kick;
    logic [MAX_CS-1:0] cs_pad;
    logic              mosi_q;
    logic              miso_q;
    logic              toggle;

    for (genvar g = 0; g < NUM_CS; g++) begin : g_ch
        ch_state_t     state;
        ch_state_t     state_d;
        logic [SW-1:0] cnt;
        logic          mnt_on;
        logic          mnt_off;
        logic          settled;
        logic          pend_d;

        // Counter tracks consecutive high cs samples only while a remap is pending;
        // the pulse cycle's own sample counts, so a low sample there clears it.
        always_comb begin
            mnt_on  = img_mounted[g] & img_nz[g];
            mnt_off = img_mounted[g] & ~img_nz[g];
            settled = cs_n_i[g] && (cnt == SMAX);
            state_d = state;
            case (state)
                BASE:    if (mnt_on) state_d = PEND_V;
                VIRT:    if (mnt_off) state_d = PEND_B;
                PEND_V:  if (mnt_off) state_d = BASE;
                         else if (settled) state_d = VIRT;
                PEND_B:  if (mnt_on) state_d = VIRT;
                         else if (settled) state_d = BASE;
                default: state_d = BASE;
            endcase
            pend_d = (state_d == PEND_V) || (state_d == PEND_B);
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                state <= BASE;
                cnt   <= '0;
            end else begin
                state <= state_d;
                if (pend_d && cs_n_i[g]) begin
                    cnt <= (cnt == SMAX) ? cnt : cnt + SW'(1);
                end else begin
                    cnt <= '0;
                end
            end
        end

        assign vsd_sel_o[g]  = (state == VIRT) || (state == PEND_B);
        assign vsd_cs_n_o[g] = cs_n_i[g] | ~vsd_sel_o[g];
        assign kick[g]       = toggle & win[g];

        if (g == 0) begin : g_phys
            assign cand[g] = vsd_sel_o[g] ? vsd_miso_i[g] : SD_MISO;
        end else begin : g_virt
            assign cand[g] = vsd_sel_o[g] ? vsd_miso_i[g] : 1'b1;
        end

        sd_act_timer #(
            .TIMEOUT(TIMEOUT)
        ) u_act (
            .clk_sys(clk_sys),
            .reset  (reset),
            .kick   (kick[g]),
            .act    (act_o[g])
        );
    end

    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (!cs_n_i[i] && !win_valid) begin
                win[i]    = 1'b1;
                win_valid = 1'b1;
            end
        end
    end

    always_comb begin
        cs_pad = '1;
        cs_pad[NUM_CS-1:0] = cs_n_i;
    end

    assign miso_o     = win_valid ? |(win & cand) : 1'b1;
    assign vsd_sclk_o = sclk_i;
    assign vsd_mosi_o = mosi_i;
    assign SD_CS      = cs_n_i[0] | vsd_sel_o[0];
    assign SD_SCK     = sclk_i & ~vsd_sel_o[0];
    assign SD_MOSI    = mosi_i & ~vsd_sel_o[0];
    assign toggle     = (mosi_i ^ mosi_q) | (miso_o ^ miso_q);

    // Data history tracks the live lines during reset so release never looks like a toggle.
    always_ff @(posedge clk_sys) begin
        mosi_q <= mosi_i;
        miso_q <= miso_o;
        if (reset) begin
            cs_conflict_o <= 1'b0;
            led_o         <= 1'b0;
        end else begin
            cs_conflict_o <= multi_low(cs_pad);
            led_o         <= (LED_MODE == LED_PHYS) ? (act_o[0] & ~vsd_sel_o[0]) : |act_o;
        end
    end

endmodule
